// File: rtl/start_fifo_srl_ctrl_if.sv
// Handshake bundle for one start-token FIFO.
//
// Carries the producer side (if_write/if_write_ce/if_din/if_full_n), the
// consumer side (if_read/if_read_ce/if_dout/if_empty_n), the occupancy
// readouts (if_num_data_valid, if_fifo_cap) and the link to the external
// SRL storage array (srl_we/srl_din/srl_addr/srl_dout).
//
// Handshake semantics: a write is accepted on a rising clk edge when
// if_write & if_write_ce & if_full_n are all high; a read is accepted when
// if_read & if_read_ce & if_empty_n are all high. if_full_n and if_empty_n
// are registered, so neither request can combinationally affect them.
//
// Modports:
//   slave  - the FIFO controller
//   master - the surrounding producer, consumer and SRL storage
interface start_fifo_srl_ctrl_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
);
    logic                  if_write;
    logic                  if_write_ce;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read;
    logic                  if_read_ce;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic [ADDR_WIDTH:0]   if_num_data_valid;
    logic [ADDR_WIDTH:0]   if_fifo_cap;
    logic                  srl_we;
    logic [DATA_WIDTH-1:0] srl_din;
    logic [ADDR_WIDTH-1:0] srl_addr;
    logic [DATA_WIDTH-1:0] srl_dout;

    modport slave (
        input  if_write, if_write_ce, if_din,
        input  if_read, if_read_ce,
        input  srl_dout,
        output if_full_n, if_dout, if_empty_n,
        output if_num_data_valid, if_fifo_cap,
        output srl_we, srl_din, srl_addr
    );

    modport master (
        output if_write, if_write_ce, if_din,
        output if_read, if_read_ce,
        output srl_dout,
        input  if_full_n, if_dout, if_empty_n,
        input  if_num_data_valid, if_fifo_cap,
        input  srl_we, srl_din, srl_addr
    );
endinterface

// File: rtl/start_fifo_srl_ctrl.sv
// Control and read side of a shift-register start-token FIFO.
//
// Tracks occupancy, drives the shift enable and read address of an external
// SRL array (slot 0 = newest entry, oldest entry at slot count-1) and returns
// the SRL read data to the consumer as a first-word-fall-through stream.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous, active-high reset
//   bus       - handshake/SRL bundle (slave modport)
//   dbg_state - current FSM state (0 EMPTY, 1 PARTIAL, 2 FULL)
module start_fifo_srl_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    start_fifo_srl_ctrl_if.slave        bus,
    output logic [1:0]                  dbg_state
);
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_TWO = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH:0] CNT_DM1 = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_CAP = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  empty_n_q, full_n_q;
    logic                  push, pop;

    // Requests are also masked while reset is held, so a producer that keeps
    // if_write high during reset cannot shift the SRL before release.
    assign push = bus.if_write & bus.if_write_ce & full_n_q & ~reset;
    assign pop  = bus.if_read  & bus.if_read_ce  & empty_n_q & ~reset;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    count_d = CNT_ONE;
                    addr_d  = '0;
                    state_d = (DEPTH == 1) ? ST_FULL : ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                // Push+pop together leaves count and address alone: the shift
                // moves the next-oldest entry into the slot just vacated.
                if (push && !pop) begin
                    count_d = count_q + CNT_ONE;
                    addr_d  = count_q[ADDR_WIDTH-1:0];
                    if (count_q == CNT_DM1) state_d = ST_FULL;
                end else if (pop && !push) begin
                    count_d = count_q - CNT_ONE;
                    addr_d  = (count_q > CNT_ONE) ? ADDR_WIDTH'(count_q - CNT_TWO) : '0;
                    if (count_q == CNT_ONE) state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // push is already blocked by full_n_q here
                if (pop) begin
                    count_d = count_q - CNT_ONE;
                    addr_d  = (count_q > CNT_ONE) ? ADDR_WIDTH'(count_q - CNT_TWO) : '0;
                    state_d = (DEPTH == 1) ? ST_EMPTY : ST_PARTIAL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                count_d = '0;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            count_q   <= '0;
            addr_q    <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            empty_n_q <= (state_d != ST_EMPTY);
            full_n_q  <= (state_d != ST_FULL);
        end
    end

    assign bus.srl_we            = push;
    assign bus.srl_din           = bus.if_din[DATA_WIDTH-1:0];
    assign bus.srl_addr          = addr_q;
    assign bus.if_dout           = bus.srl_dout;
    assign bus.if_empty_n        = empty_n_q;
    assign bus.if_full_n         = full_n_q;
    assign bus.if_num_data_valid = count_q;
    assign bus.if_fifo_cap       = CNT_CAP;
    assign dbg_state             = state_q;
endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// Directed bench for start_fifo_srl_ctrl with DEPTH = 2, 4 and 1 instances,
// each backed by a small behavioural SRL array.
module tb_start_fifo_srl_ctrl;
    logic clk;
    logic rst2, rst4, rst1;
    logic [1:0] st2, st4, st1;

    start_fifo_srl_ctrl_if #(.DATA_WIDTH(1), .ADDR_WIDTH(1)) b2();
    start_fifo_srl_ctrl_if #(.DATA_WIDTH(1), .ADDR_WIDTH(2)) b4();
    start_fifo_srl_ctrl_if #(.DATA_WIDTH(1), .ADDR_WIDTH(1)) b1();

    start_fifo_srl_ctrl #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(2)) dut2 (
        .clk(clk), .reset(rst2), .bus(b2.slave), .dbg_state(st2));
    start_fifo_srl_ctrl #(.DATA_WIDTH(1), .ADDR_WIDTH(2), .DEPTH(4)) dut4 (
        .clk(clk), .reset(rst4), .bus(b4.slave), .dbg_state(st4));
    start_fifo_srl_ctrl #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(1)) dut1 (
        .clk(clk), .reset(rst1), .bus(b1.slave), .dbg_state(st1));

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- SRL storage models (slot 0 = newest) ----------------
    logic mem2 [2];
    logic mem4 [4];
    logic mem1 [2];

    always @(posedge clk) begin
        if (b2.srl_we) begin
            mem2[1] <= mem2[0];
            mem2[0] <= b2.srl_din;
        end
        if (b4.srl_we) begin
            for (int i = 3; i > 0; i--) mem4[i] <= mem4[i-1];
            mem4[0] <= b4.srl_din;
        end
        if (b1.srl_we) begin
            mem1[1] <= mem1[0];
            mem1[0] <= b1.srl_din;
        end
    end

    assign b2.srl_dout = mem2[b2.srl_addr];
    assign b4.srl_dout = mem4[b4.srl_addr];
    assign b1.srl_dout = mem1[b1.srl_addr];

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // in = {if_write, if_write_ce, if_din, if_read, if_read_ce}
    task automatic drive2(input logic [4:0] in);
        {b2.if_write, b2.if_write_ce, b2.if_din, b2.if_read, b2.if_read_ce} = in;
    endtask
    task automatic drive4(input logic [4:0] in);
        {b4.if_write, b4.if_write_ce, b4.if_din, b4.if_read, b4.if_read_ce} = in;
    endtask
    task automatic drive1(input logic [4:0] in);
        {b1.if_write, b1.if_write_ce, b1.if_din, b1.if_read, b1.if_read_ce} = in;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- DEPTH=4 vector table ----------------
    // flg = {srl_we before the edge, if_empty_n, if_full_n after the edge}
    typedef struct {
        logic [4:0] in;
        logic [2:0] flg;
        logic [2:0] cnt;
        logic [1:0] addr;
        logic       dout;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst2 = 1'b1; rst4 = 1'b1; rst1 = 1'b1;
        drive2(5'b0); drive4(5'b0); drive1(5'b0);

        tbl[0]  = '{5'b11100, 3'b111, 3'd1, 2'd0, 1'b1};
        tbl[1]  = '{5'b11000, 3'b111, 3'd2, 2'd1, 1'b1};
        tbl[2]  = '{5'b11111, 3'b111, 3'd2, 2'd1, 1'b0};
        tbl[3]  = '{5'b11011, 3'b111, 3'd2, 2'd1, 1'b1};
        tbl[4]  = '{5'b11111, 3'b111, 3'd2, 2'd1, 1'b0};
        tbl[5]  = '{5'b11111, 3'b111, 3'd2, 2'd1, 1'b1};
        tbl[6]  = '{5'b11011, 3'b111, 3'd2, 2'd1, 1'b1};
        tbl[7]  = '{5'b11111, 3'b111, 3'd2, 2'd1, 1'b0};
        tbl[8]  = '{5'b10110, 3'b011, 3'd2, 2'd1, 1'b0};
        tbl[9]  = '{5'b11100, 3'b111, 3'd3, 2'd2, 1'b0};
        tbl[10] = '{5'b11000, 3'b110, 3'd4, 2'd3, 1'b0};
        tbl[11] = '{5'b11100, 3'b010, 3'd4, 2'd3, 1'b0};
        tbl[12] = '{5'b11111, 3'b011, 3'd3, 2'd2, 1'b1};
        tbl[13] = '{5'b00011, 3'b011, 3'd2, 2'd1, 1'b1};
        tbl[14] = '{5'b00011, 3'b011, 3'd1, 2'd0, 1'b0};
        tbl[15] = '{5'b00011, 3'b001, 3'd0, 2'd0, 1'b0};
        tbl[16] = '{5'b00011, 3'b001, 3'd0, 2'd0, 1'b0};
        tbl[17] = '{5'b11111, 3'b111, 3'd1, 2'd0, 1'b1};
        tbl[18] = '{5'b00011, 3'b001, 3'd0, 2'd0, 1'b0};

        // ---- DEPTH=2: reset with a write held, then fill/drain ----
        drive2(5'b11100);
        repeat (2) tick();
        check("d2_rst_empty_n", int'(b2.if_empty_n), 0);
        check("d2_rst_full_n", int'(b2.if_full_n), 1);
        check("d2_rst_count", int'(b2.if_num_data_valid), 0);
        check("d2_rst_srl_we", int'(b2.srl_we), 0);
        check("d2_fifo_cap", int'(b2.if_fifo_cap), 2);

        rst2 = 1'b0;
        exp_q.push_back(1'b1);
        tick();
        check("d2_push1_empty_n", int'(b2.if_empty_n), 1);
        check("d2_push1_count", int'(b2.if_num_data_valid), 1);
        check("d2_push1_dout", int'(b2.if_dout), int'(exp_q[0]));

        drive2(5'b11000);
        exp_q.push_back(1'b0);
        tick();
        check("d2_push2_full_n", int'(b2.if_full_n), 0);
        check("d2_push2_count", int'(b2.if_num_data_valid), 2);

        drive2(5'b11100);
        #1;
        check("d2_full_srl_we", int'(b2.srl_we), 0);
        tick();
        check("d2_full_count", int'(b2.if_num_data_valid), 2);
        check("d2_head_dout", int'(b2.if_dout), int'(exp_q[0]));

        drive2(5'b00011);
        tick();
        void'(exp_q.pop_front());
        check("d2_pop1_dout", int'(b2.if_dout), int'(exp_q[0]));
        check("d2_pop1_full_n", int'(b2.if_full_n), 1);
        tick();
        void'(exp_q.pop_front());
        check("d2_pop2_empty_n", int'(b2.if_empty_n), 0);
        check("d2_pop2_count", int'(b2.if_num_data_valid), 0);
        drive2(5'b0);

        // ---- DEPTH=4: table ----
        rst4 = 1'b0;
        tick();
        for (int i = 0; i < NV; i++) begin
            drive4(tbl[i].in);
            #1;
            check($sformatf("d4_v%0d_srl_we", i), int'(b4.srl_we), int'(tbl[i].flg[2]));
            tick();
            check($sformatf("d4_v%0d_empty_n", i), int'(b4.if_empty_n), int'(tbl[i].flg[1]));
            check($sformatf("d4_v%0d_full_n", i), int'(b4.if_full_n), int'(tbl[i].flg[0]));
            check($sformatf("d4_v%0d_count", i), int'(b4.if_num_data_valid), int'(tbl[i].cnt));
            check($sformatf("d4_v%0d_addr", i), int'(b4.srl_addr), int'(tbl[i].addr));
            if (tbl[i].flg[1])
                check($sformatf("d4_v%0d_dout", i), int'(b4.if_dout), int'(tbl[i].dout));
        end

        // ---- DEPTH=4: asynchronous reset with 3 entries queued ----
        drive4(5'b11100); tick();
        drive4(5'b11000); tick();
        drive4(5'b11100); tick();
        drive4(5'b0);
        check("d4_pre_rst_count", int'(b4.if_num_data_valid), 3);
        #2;
        rst4 = 1'b1;
        #1;
        check("d4_arst_empty_n", int'(b4.if_empty_n), 0);
        check("d4_arst_full_n", int'(b4.if_full_n), 1);
        check("d4_arst_count", int'(b4.if_num_data_valid), 0);
        check("d4_arst_addr", int'(b4.srl_addr), 0);
        #2;
        rst4 = 1'b0;
        tick();
        check("d4_post_rst_empty_n", int'(b4.if_empty_n), 0);
        drive4(5'b11000);
        tick();
        check("d4_new_dout", int'(b4.if_dout), 0);
        check("d4_new_count", int'(b4.if_num_data_valid), 1);
        drive4(5'b00011);
        tick();
        check("d4_new_pop_empty_n", int'(b4.if_empty_n), 0);
        check("d4_new_pop_count", int'(b4.if_num_data_valid), 0);
        drive4(5'b0);

        // ---- DEPTH=1 ----
        rst1 = 1'b0;
        tick();
        check("d1_fifo_cap", int'(b1.if_fifo_cap), 1);
        drive1(5'b11100);
        tick();
        check("d1_push_empty_n", int'(b1.if_empty_n), 1);
        check("d1_push_full_n", int'(b1.if_full_n), 0);
        check("d1_push_addr", int'(b1.srl_addr), 0);
        check("d1_push_count", int'(b1.if_num_data_valid), 1);
        check("d1_push_dout", int'(b1.if_dout), 1);
        drive1(5'b11011);
        #1;
        check("d1_pushpop_srl_we", int'(b1.srl_we), 0);
        tick();
        check("d1_pop_empty_n", int'(b1.if_empty_n), 0);
        check("d1_pop_full_n", int'(b1.if_full_n), 1);
        check("d1_pop_count", int'(b1.if_num_data_valid), 0);
        drive1(5'b0);
        tick();
        check("d1_idle_count", int'(b1.if_num_data_valid), 0);
        check("d1_idle_empty_n", int'(b1.if_empty_n), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
